// File: rtl/router_pkg.sv
// router_pkg: handshake protocol selector and port-buffer FSM state encodings
package router_pkg;
    typedef enum logic {HS_FOUR_PHASE = 1'b0, HS_TWO_PHASE = 1'b1} hs_mode_e;
    typedef enum logic {IN_IDLE, IN_ACKED} in_state_e;
    typedef enum logic [1:0] {OUT_IDLE, OUT_REQ, OUT_WAIT} out_state_e;
endpackage

// File: rtl/rt_fifo.sv
// rt_fifo: DEPTH-entry in-order flit storage with modulo-wrapping pointers
module rt_fifo #(
    parameter int WIDTH = 512,
    parameter int DEPTH = 4
)(
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         push,
    input  logic                         pop,
    input  logic [WIDTH-1:0]             wdata,
    output logic [WIDTH-1:0]             head,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         full,
    output logic                         empty
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wptr, rptr;
    // DEPTH need not be a power of two, so wrap explicitly
    function automatic logic [AW-1:0] nxt(input logic [AW-1:0] p);
        return p == AW'(DEPTH - 1) ? '0 : p + 1'b1;
    endfunction
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push) wptr <= nxt(wptr);
            if (pop) rptr <= nxt(rptr);
            count <= count + CW'(push) - CW'(pop);
        end
    always_ff @(posedge clk)
        if (push) mem[wptr] <= wdata;
    assign head  = mem[rptr];
    assign full  = count == CW'(DEPTH);
    assign empty = count == '0;
    a_no_underflow: assert property (@(posedge clk) disable iff (!rst_n) pop |-> !empty);
    a_no_overflow:  assert property (@(posedge clk) disable iff (!rst_n) push |-> !full);
endmodule

// File: rtl/rt_port_buffer.sv
// rt_port_buffer: buffered link stage between two req/ack flit channels,
// four-phase or two-phase handshake on both sides
module rt_port_buffer
    import router_pkg::*;
#(
    parameter int       WIDTH = 512,
    parameter int       DEPTH = 4,
    parameter hs_mode_e MODE  = HS_FOUR_PHASE
)(
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         in_req,
    input  logic [WIDTH-1:0]             in_data,
    output logic                         in_ack,
    output logic                         out_req,
    output logic [WIDTH-1:0]             out_data,
    input  logic                         out_ack,
    output logic [$clog2(DEPTH+1)-1:0]   count
);
    localparam bit FOUR = MODE == HS_FOUR_PHASE;
    in_state_e        in_st;
    out_state_e       out_st;
    logic             push, pop, issue, full, empty;
    logic [WIDTH-1:0] head;
    // full comes from the registered count, so a same-edge pop never frees a slot
    always_comb begin
        push  = !full && (FOUR ? in_st == IN_IDLE && in_req : in_req != in_ack);
        pop   = out_st == OUT_REQ && (FOUR ? out_ack : out_ack == out_req);
        issue = out_st == OUT_IDLE && !empty && (FOUR ? !out_ack : out_ack == out_req);
    end
    rt_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (pop),
        .wdata (in_data),
        .head  (head),
        .count (count),
        .full  (full),
        .empty (empty)
    );
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            in_st  <= IN_IDLE;
            in_ack <= 1'b0;
        end else if (FOUR) begin
            if (push) begin
                in_st  <= IN_ACKED;
                in_ack <= 1'b1;
            end else if (in_st == IN_ACKED && !in_req) begin
                in_st  <= IN_IDLE;
                in_ack <= 1'b0;
            end
        end else if (push) begin
            in_ack <= ~in_ack;
        end
    // the head stays in the FIFO until acknowledged; out_data holds a registered copy
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            out_st   <= OUT_IDLE;
            out_req  <= 1'b0;
            out_data <= '0;
        end else if (issue) begin
            out_st   <= OUT_REQ;
            out_req  <= FOUR ? 1'b1 : ~out_req;
            out_data <= head;
        end else if (pop) begin
            out_st <= FOUR ? OUT_WAIT : OUT_IDLE;
            if (FOUR) out_req <= 1'b0;
        end else if (out_st == OUT_WAIT && !out_ack) begin
            out_st <= OUT_IDLE;
        end
endmodule

// File: doc/rt_port_buffer.md
Name: rt_port_buffer

Overview:
- Parametrised buffered link stage between two RTPort-style req/ack/data channels.
- Accepts flits on an upstream handshake and stores them in a DEPTH-entry FIFO.
- Re-issues stored flits in order on a downstream handshake.
- Handshake protocol is selectable: four-phase (return-to-zero) or two-phase (transition signalling). Lets router ports decouple and absorb back-pressure.

Parameters:
- WIDTH, 512, flit data width in bits.
- DEPTH, 4, FIFO entries; legal range 2..64, power of two not required.
- MODE, HS_FOUR_PHASE, handshake protocol on both sides (hs_mode_e from router_pkg).

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_req  input  1  upstream request.
- in_data  input  WIDTH  upstream flit; valid while a request is pending.
- in_ack  output  1  upstream acknowledge, registered.
- out_req  output  1  downstream request, registered.
- out_data  output  WIDTH  FIFO head; stable while a request is pending.
- out_ack  input  1  downstream acknowledge.
- count  output  $clog2(DEPTH+1)  current occupancy, registered.

Behaviour:
- Reset (async assert, sync-safe deassert): in_ack=0, out_req=0, count=0, FIFO pointers=0. out_data is don't-care but driven 0 by reset of head register.
- Reset mid-handshake abandons the transfer: the flit is lost; no replay.
- Input side, four-phase: states IN_IDLE, IN_ACKED.
  - IN_IDLE with in_req=1 and count<DEPTH: write in_data at that edge, in_ack=1, go to IN_ACKED.
  - IN_ACKED: hold in_ack=1 until in_req=0 is sampled, then in_ack=0, go to IN_IDLE.
  - Exactly one write per handshake.
- Input side, two-phase: pending when in_req != in_ack. If pending and count<DEPTH: write, toggle in_ack.
- Full is decided on registered count. A push is refused when count==DEPTH even if a pop occurs the same edge. The request stays pending and is serviced on a later edge.
- Output side, four-phase: states OUT_IDLE, OUT_REQ, OUT_WAIT.
  - OUT_IDLE with count>0 and out_ack=0: load head to out_data, out_req=1, go to OUT_REQ.
  - OUT_REQ with out_ack=1 sampled: pop, out_req=0, go to OUT_WAIT.
  - OUT_WAIT with out_ack=0: go to OUT_IDLE.
- Output side, two-phase: when out_req==out_ack and count>0, load head and toggle out_req. When out_ack equals the new out_req, pop; the next flit may be issued on the following edge.
- out_data changes only when a new request is issued.
- Latency: in_req sampled at edge k → in_ack and count updated after k. out_req is asserted after edge k+1 at earliest (empty buffer).
- Simultaneous push and pop at the same edge: count unchanged; pointers both advance; data ordering preserved.
- Pointer wrap: read/write pointers wrap at DEPTH-1 → 0 (modulo, not power-of-two masking).
- count never exceeds DEPTH and never underflows. Pop happens only when count>0 by construction; the assertion checks this.
- in_data is sampled only at the write edge; changes outside a pending request are ignored.

Decomposition:
- router_pkg gains typedef enum hs_mode_e {HS_FOUR_PHASE=0, HS_TWO_PHASE=1}.
- router_pkg gains the in/out FSM state enums (in_state_e, out_state_e).
- Sub-module rt_fifo (WIDTH, DEPTH): synchronous storage with push, pop, head, count, full, empty. It is the natural split.
- rt_port_buffer holds the two handshake FSMs and instantiates rt_fifo.

Test Plan:
- Four-phase, DEPTH=4, single flit 0xA5: in_ack rises 1 cycle after in_req; out_req rises 1 cycle later with out_data=0xA5. Apply out_ack, then drop it → count back to 0.
- Four-phase fill: push 0x1..0x5 with out_ack held 0. The first four are acked and count=4; the fifth in_req sees in_ack stay 0. Pop one → fifth acked; output order is 1,2,3,4,5.
- Two-phase, DEPTH=3: toggle in_req 6 times while the downstream echoes out_req on out_ack after 2 cycles. All 6 flits (0x10..0x15) arrive in order; count never exceeds 3; pointers wrap twice.
- Simultaneous push/pop at count=2: out_ack completes on the same edge a new push is written → count stays 2; head advances correctly.
- Full with simultaneous pop at count==DEPTH: push is refused that edge and accepted on the next; no data loss or duplication.
- Reset asserted mid-transfer with in_ack=1 and out_req=1: immediately in_ack=0, out_req=0, count=0. After release, the first new flit 0x77 is delivered correctly.
